iob_fifo_sync_prog: RTL and testbench
=====================================

# iob_fifo_sync_prog

Synchronous FIFO with asymmetric write/read widths. It uses internal register-array storage and has a selectable read mode: standard (registered, 1-cycle latency) or first-word-fall-through. It also provides programmable almost-full/almost-empty thresholds and sticky overflow/underflow error flags. It sits between single-clock producers and consumers of different widths, for example byte streams feeding word datapaths, and needs no external RAM port.

## Interface
Parameters:
- W_DATA_W, 8: write word width.
- R_DATA_W, 8: read word width. MAX(W_DATA_W,R_DATA_W)/MIN(W_DATA_W,R_DATA_W) = N must be a power of 2.
- ADDR_W, 4: capacity is 2^ADDR_W words of MIN(W_DATA_W,R_DATA_W). Must satisfy ADDR_W >= log2(N)+1.
- FWFT, 0: 0 = standard read; 1 = first-word-fall-through.

Ports:
- clk  in  1  clock. Single clock domain; reset is synchronous and active-high.
- rst  in  1  synchronous active-high reset.
- w_en  in  1  write request.
- w_data  in  W_DATA_W  write data.
- w_full  out  1  registered; no room for one write word.
- w_almost_full  out  1  registered; level >= afull_lvl.
- r_en  in  1  read request.
- r_data  out  R_DATA_W  read data.
- r_empty  out  1  registered; less than one read word stored.
- r_almost_empty  out  1  registered; level <= aempty_lvl.
- afull_lvl  in  ADDR_W+1  almost-full threshold, in MIN-width units.
- aempty_lvl  in  ADDR_W+1  almost-empty threshold, in MIN-width units.
- err_clr  in  1  clears the sticky error flags.
- overflow  out  1  sticky; a write was attempted while full.
- underflow  out  1  sticky; a read was attempted while empty.
- level  out  ADDR_W+1  registered occupancy, in MIN-width units.

## Operation
- Accept rules:
  - w_acc = w_en & ~w_full.
  - r_acc = r_en & ~r_empty.
  - Rejected requests change no state other than the error flags.
- Increments:
  - w_incr = N if W_DATA_W is the wider width, else 1.
  - r_incr = N if R_DATA_W is the wider width, else 1.
  - Equal widths: both are 1.
- level_nxt = level + (w_acc ? w_incr : 0) - (r_acc ? r_incr : 0). Compute it ADDR_W+2 bits wide; it never exceeds 2^ADDR_W.
- Flags, all registered from level_nxt:
  - w_full = level_nxt > 2^ADDR_W - w_incr.
  - r_empty = level_nxt < r_incr.
  - w_almost_full = level_nxt >= afull_lvl.
  - r_almost_empty = level_nxt <= aempty_lvl.
- Pointers:
  - Write and read pointers are counters in their own word units and wrap modulo their depth.
  - Storage is 2^ADDR_W MIN-width cells.
- Width packing is little-endian:
  - Wide write: w_data[MIN-1:0] is read out first.
  - Wide read: the earliest stored narrow word lands in r_data[MIN-1:0].
- Standard mode (FWFT=0): r_data loads the head word on the clock edge that accepts a read, and holds otherwise.
- FWFT mode (FWFT=1):
  - r_data continuously shows the head word whenever r_empty=0.
  - r_en acts as a pop/acknowledge.
  - r_data is don't-care while r_empty=1.
- Simultaneous read and write:
  - Both are accepted if both are individually legal.
  - A full FIFO rejects the write even if a read is accepted in the same cycle, because w_full is registered.
  - An empty FIFO rejects the read even if a write is accepted in the same cycle.
- Error flags:
  - overflow sets on w_en & w_full; underflow sets on r_en & r_empty.
  - err_clr clears both; a set condition in the same cycle wins over err_clr.
- Threshold inputs may change at any time; the new value takes effect in the flags one cycle later.

## Timing
- Reset values:
  - level=0, r_empty=1, w_full=0, r_almost_empty=1, w_almost_full=0, overflow=0, underflow=0, r_data=0.
  - Pointers reset to 0.
  - Storage contents are not reset.
- Reset mid-operation discards all stored data. The first cycle after rst deasserts behaves as empty.
- Write-to-visibility latency:
  - The cycle after the first accepted write that brings level >= r_incr, r_empty=0.
  - FWFT: r_data is valid in that same cycle.
  - Standard: r_data is valid 1 cycle after the accepting r_en edge.
- level and all flags update 1 cycle after the accepting edge.
- Throughput: one write and one read per cycle, sustained.

## Test plan
- Symmetric 8/8, ADDR_W=4, FWFT=0:
  - Write 16 words 0x00..0x0F -> w_full=1 after the 16th write, level=16.
  - 17th write -> rejected, overflow=1.
  - Read 16 -> r_data=0x00..0x0F, each 1 cycle after its read; r_empty=1 and level=0 at the end.
- Asymmetric write 32 / read 8, ADDR_W=4, FWFT=1:
  - Write 0x44332211 -> next cycle r_empty=0, r_data=0x11, level=4.
  - Pops return 0x22, 0x33, 0x44.
  - After 4 writes with no reads -> w_full=1.
- Asymmetric write 8 / read 32, ADDR_W=4:
  - Write 0xAA, 0xBB, 0xCC -> r_empty stays 1.
  - Write 0xDD -> r_empty=0; the read returns 0xDDCCBBAA.
- Thresholds afull_lvl=12, aempty_lvl=3, 8/8:
  - Fill 0..16 -> w_almost_full rises one cycle after the 12th write.
  - r_almost_empty falls after the 4th write.
- Wrap and simultaneous access, 8/8:
  - Sustain 40 cycles of concurrent w_en/r_en at level 5 -> level stays 5 and the data order is preserved across pointer wrap.
  - r_en while empty -> underflow=1.
  - err_clr -> both error flags 0.
- Reset mid-stream at level 9 -> next cycle level=0, r_empty=1, w_full=0, flags cleared.

Source files
------------

// File: rtl/iob_fifo_sync_prog.sv
// Synchronous FIFO with asymmetric write/read widths over register-array storage,
// selectable standard or first-word-fall-through reads, programmable thresholds and sticky errors.
module iob_fifo_sync_prog #(
  parameter int W_DATA_W = 8,
  parameter int R_DATA_W = 8,
  parameter int ADDR_W   = 4,
  parameter int FWFT     = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                w_en,
  input  logic [W_DATA_W-1:0] w_data,
  output logic                w_full,
  output logic                w_almost_full,
  input  logic                r_en,
  output logic [R_DATA_W-1:0] r_data,
  output logic                r_empty,
  output logic                r_almost_empty,
  input  logic [ADDR_W:0]     afull_lvl,
  input  logic [ADDR_W:0]     aempty_lvl,
  input  logic                err_clr,
  output logic                overflow,
  output logic                underflow,
  output logic [ADDR_W:0]     level
);

  localparam int MIN_W   = (W_DATA_W < R_DATA_W) ? W_DATA_W : R_DATA_W;
  localparam int MAX_W   = (W_DATA_W < R_DATA_W) ? R_DATA_W : W_DATA_W;
  localparam int N       = MAX_W / MIN_W;
  localparam int LOG_N   = $clog2(N);
  localparam int ROW_W   = ADDR_W - LOG_N;
  localparam int ROWS    = 2 ** ROW_W;
  localparam int DEPTH   = 2 ** ADDR_W;
  localparam int W_INCR  = (W_DATA_W > R_DATA_W) ? N : 1;
  localparam int R_INCR  = (R_DATA_W > W_DATA_W) ? N : 1;
  localparam int W_PTR_W = (W_DATA_W >= R_DATA_W) ? ROW_W : ADDR_W;
  localparam int R_PTR_W = (R_DATA_W >= W_DATA_W) ? ROW_W : ADDR_W;
  localparam int LVL_W   = ADDR_W + 2;

  // Storage is organised as rows of one wide word; the narrow side addresses lanes inside a row.
  logic [MAX_W-1:0]    mem [ROWS];
  logic [W_PTR_W-1:0]  w_ptr;
  logic [R_PTR_W-1:0]  r_ptr;
  logic [R_DATA_W-1:0] head;
  logic                w_acc;
  logic                r_acc;
  logic [LVL_W-1:0]    level_nxt;

  assign w_acc = w_en & ~w_full;
  assign r_acc = r_en & ~r_empty;

  // NOTE: combinational blocks assign a default first and use blocking '=' so no latch is inferred.
  always_comb begin
    level_nxt = {1'b0, level};
    if (w_acc) level_nxt = level_nxt + LVL_W'(W_INCR);
    if (r_acc) level_nxt = level_nxt - LVL_W'(R_INCR);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      level          <= '0;
      w_full         <= 1'b0;
      r_empty        <= 1'b1;
      w_almost_full  <= 1'b0;
      r_almost_empty <= 1'b1;
      w_ptr          <= '0;
      r_ptr          <= '0;
    end else begin
      level          <= level_nxt[ADDR_W:0];
      w_full         <= level_nxt > LVL_W'(DEPTH - W_INCR);
      r_empty        <= level_nxt < LVL_W'(R_INCR);
      w_almost_full  <= level_nxt >= {1'b0, afull_lvl};
      r_almost_empty <= level_nxt <= {1'b0, aempty_lvl};
      if (w_acc) w_ptr <= w_ptr + W_PTR_W'(1);
      if (r_acc) r_ptr <= r_ptr + R_PTR_W'(1);
    end
  end

  // A detected error condition takes priority over a clear in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (w_en && w_full)   overflow <= 1'b1;
      else if (err_clr)     overflow <= 1'b0;
      if (r_en && r_empty)  underflow <= 1'b1;
      else if (err_clr)     underflow <= 1'b0;
    end
  end

  // NOTE: storage has no reset; the pointers and level alone define what is valid.
  generate
    if (W_DATA_W >= R_DATA_W) begin : g_wide_wr
      always_ff @(posedge clk) begin
        if (w_acc) mem[w_ptr] <= w_data;
      end
    end else begin : g_narrow_wr
      logic [ROW_W-1:0] w_row;
      logic [LOG_N-1:0] w_lane;
      assign w_row  = w_ptr[ADDR_W-1:LOG_N];
      assign w_lane = w_ptr[LOG_N-1:0];
      always_ff @(posedge clk) begin
        if (w_acc) mem[w_row][w_lane*MIN_W +: MIN_W] <= w_data;
      end
    end
  endgenerate

  generate
    if (R_DATA_W >= W_DATA_W) begin : g_wide_rd
      assign head = mem[r_ptr];
    end else begin : g_narrow_rd
      logic [ROW_W-1:0] r_row;
      logic [LOG_N-1:0] r_lane;
      assign r_row  = r_ptr[ADDR_W-1:LOG_N];
      assign r_lane = r_ptr[LOG_N-1:0];
      assign head   = mem[r_row][r_lane*MIN_W +: MIN_W];
    end
  endgenerate

  generate
    if (FWFT != 0) begin : g_fwft
      assign r_data = head;
    end else begin : g_std
      always_ff @(posedge clk) begin
        if (rst)        r_data <= '0;
        else if (r_acc) r_data <= head;
      end
    end
  endgenerate

endmodule

// File: tb/tb_iob_fifo_sync_prog.sv
// Bench for iob_fifo_sync_prog: three width/mode variants checked against a byte-list model
// with directed scenarios followed by randomized traffic.
module tb_iob_fifo_sync_prog;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // unit 0: 8/8 standard, unit 1: 32/8 FWFT, unit 2: 8/32 standard
  logic       we0, re0, clr0, wf0, waf0, rem0, rae0, ov0, un0;
  logic [7:0] wd0, rd0;
  logic [4:0] afl0, ael0, lvl0;

  logic        we1, re1, clr1, wf1, waf1, rem1, rae1, ov1, un1;
  logic [31:0] wd1;
  logic [7:0]  rd1;
  logic [4:0]  afl1, ael1, lvl1;

  logic        we2, re2, clr2, wf2, waf2, rem2, rae2, ov2, un2;
  logic [7:0]  wd2;
  logic [31:0] rd2;
  logic [4:0]  afl2, ael2, lvl2;

  iob_fifo_sync_prog #(.W_DATA_W(8), .R_DATA_W(8), .ADDR_W(4), .FWFT(0)) u0 (
    .clk(clk), .rst(rst), .w_en(we0), .w_data(wd0), .w_full(wf0), .w_almost_full(waf0),
    .r_en(re0), .r_data(rd0), .r_empty(rem0), .r_almost_empty(rae0),
    .afull_lvl(afl0), .aempty_lvl(ael0), .err_clr(clr0),
    .overflow(ov0), .underflow(un0), .level(lvl0));

  iob_fifo_sync_prog #(.W_DATA_W(32), .R_DATA_W(8), .ADDR_W(4), .FWFT(1)) u1 (
    .clk(clk), .rst(rst), .w_en(we1), .w_data(wd1), .w_full(wf1), .w_almost_full(waf1),
    .r_en(re1), .r_data(rd1), .r_empty(rem1), .r_almost_empty(rae1),
    .afull_lvl(afl1), .aempty_lvl(ael1), .err_clr(clr1),
    .overflow(ov1), .underflow(un1), .level(lvl1));

  iob_fifo_sync_prog #(.W_DATA_W(8), .R_DATA_W(32), .ADDR_W(4), .FWFT(0)) u2 (
    .clk(clk), .rst(rst), .w_en(we2), .w_data(wd2), .w_full(wf2), .w_almost_full(waf2),
    .r_en(re2), .r_data(rd2), .r_empty(rem2), .r_almost_empty(rae2),
    .afull_lvl(afl2), .aempty_lvl(ael2), .err_clr(clr2),
    .overflow(ov2), .underflow(un2), .level(lvl2));

  // Reference model: each FIFO is an ordered list of bytes, oldest at index 0.
  int          wi [3] = '{1, 4, 1};
  int          ri [3] = '{1, 1, 4};
  int          fw [3] = '{0, 1, 0};
  logic [7:0]  m_buf [3][16];
  int          m_cnt [3];
  logic        m_ov [3], m_un [3], m_af [3], m_ae [3];
  logic [31:0] m_rd [3];

  function automatic logic [31:0] head_val(input int id);
    logic [31:0] v = '0;
    for (int k = 0; k < ri[id]; k++) v[k*8 +: 8] = m_buf[id][k];
    return v;
  endfunction

  task automatic model_reset();
    for (int id = 0; id < 3; id++) begin
      m_cnt[id] = 0;
      m_ov[id]  = 1'b0;
      m_un[id]  = 1'b0;
      m_af[id]  = 1'b0;
      m_ae[id]  = 1'b1;
      m_rd[id]  = '0;
    end
  endtask

  task automatic model_step(input int id, input logic we, input logic [31:0] wd, input logic re,
                            input logic [4:0] afl, input logic [4:0] ael, input logic clr);
    logic full, empty;
    full  = m_cnt[id] > 16 - wi[id];
    empty = m_cnt[id] < ri[id];
    if (re && !empty) begin
      if (fw[id] == 0) m_rd[id] = head_val(id);
      for (int j = 0; j < m_cnt[id] - ri[id]; j++) m_buf[id][j] = m_buf[id][j + ri[id]];
      m_cnt[id] -= ri[id];
    end
    if (we && !full) begin
      for (int k = 0; k < wi[id]; k++) begin
        m_buf[id][m_cnt[id]] = wd[k*8 +: 8];
        m_cnt[id]++;
      end
    end
    if (we && full) m_ov[id] = 1'b1;
    else if (clr)   m_ov[id] = 1'b0;
    if (re && empty) m_un[id] = 1'b1;
    else if (clr)    m_un[id] = 1'b0;
    m_af[id] = m_cnt[id] >= int'(afl);
    m_ae[id] = m_cnt[id] <= int'(ael);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input int id, input logic [4:0] lvl, input logic wf, input logic waf,
                           input logic rem, input logic rae, input logic ov, input logic un,
                           input logic [31:0] rdat);
    chk($sformatf("u%0d_level", id), 32'(lvl), 32'(m_cnt[id]));
    chk($sformatf("u%0d_w_full", id), 32'(wf), 32'(m_cnt[id] > 16 - wi[id]));
    chk($sformatf("u%0d_r_empty", id), 32'(rem), 32'(m_cnt[id] < ri[id]));
    chk($sformatf("u%0d_almost_full", id), 32'(waf), 32'(m_af[id]));
    chk($sformatf("u%0d_almost_empty", id), 32'(rae), 32'(m_ae[id]));
    chk($sformatf("u%0d_overflow", id), 32'(ov), 32'(m_ov[id]));
    chk($sformatf("u%0d_underflow", id), 32'(un), 32'(m_un[id]));
    if (fw[id] == 0)              chk($sformatf("u%0d_r_data", id), rdat, m_rd[id]);
    else if (m_cnt[id] >= ri[id]) chk($sformatf("u%0d_r_data", id), rdat, head_val(id));
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) model_reset();
    else begin
      model_step(0, we0, 32'(wd0), re0, afl0, ael0, clr0);
      model_step(1, we1, wd1, re1, afl1, ael1, clr1);
      model_step(2, we2, 32'(wd2), re2, afl2, ael2, clr2);
    end
    #1;
    check_all(0, lvl0, wf0, waf0, rem0, rae0, ov0, un0, 32'(rd0));
    check_all(1, lvl1, wf1, waf1, rem1, rae1, ov1, un1, 32'(rd1));
    check_all(2, lvl2, wf2, waf2, rem2, rae2, ov2, un2, rd2);
  endtask

  task automatic idle_inputs();
    we0 = 1'b0; re0 = 1'b0; clr0 = 1'b0;
    we1 = 1'b0; re1 = 1'b0; clr1 = 1'b0;
    we2 = 1'b0; re2 = 1'b0; clr2 = 1'b0;
  endtask

  initial begin
    logic [7:0] exp_b [3];
    rst = 1'b1;
    idle_inputs();
    wd0 = '0; wd1 = '0; wd2 = '0;
    afl0 = 5'd12; ael0 = 5'd3;
    afl1 = 5'd14; ael1 = 5'd2;
    afl2 = 5'd8;  ael2 = 5'd4;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_level", 32'(lvl0), 32'd0);
    chk("rst_r_empty", 32'(rem0), 32'd1);
    chk("rst_w_full", 32'(wf0), 32'd0);
    chk("rst_almost_empty", 32'(rae0), 32'd1);
    chk("rst_r_data", 32'(rd0), 32'd0);

    // Fill 8/8 unit with 0x00..0x0F, watching both thresholds.
    for (int i = 0; i < 16; i++) begin
      we0 = 1'b1; wd0 = 8'(i);
      tick();
      if (i == 2)  chk("aempty_after_3", 32'(rae0), 32'd1);
      if (i == 3)  chk("aempty_after_4", 32'(rae0), 32'd0);
      if (i == 10) chk("afull_after_11", 32'(waf0), 32'd0);
      if (i == 11) chk("afull_after_12", 32'(waf0), 32'd1);
    end
    chk("fill_full", 32'(wf0), 32'd1);
    chk("fill_level", 32'(lvl0), 32'd16);
    wd0 = 8'hFF;
    tick();
    we0 = 1'b0;
    chk("overflow_set", 32'(ov0), 32'd1);
    chk("overflow_level", 32'(lvl0), 32'd16);

    for (int i = 0; i < 16; i++) begin
      re0 = 1'b1;
      tick();
      chk($sformatf("drain_data_%0d", i), 32'(rd0), 32'(i));
    end
    chk("drain_empty", 32'(rem0), 32'd1);
    chk("drain_level", 32'(lvl0), 32'd0);
    tick();
    re0 = 1'b0;
    chk("underflow_set", 32'(un0), 32'd1);
    clr0 = 1'b1;
    tick();
    clr0 = 1'b0;
    chk("clr_overflow", 32'(ov0), 32'd0);
    chk("clr_underflow", 32'(un0), 32'd0);

    // Concurrent traffic at level 5 across pointer wrap.
    for (int i = 0; i < 5; i++) begin
      we0 = 1'b1; wd0 = 8'(8'h50 + i);
      tick();
    end
    re0 = 1'b1;
    for (int i = 0; i < 40; i++) begin
      wd0 = 8'($urandom);
      tick();
      chk("steady_level", 32'(lvl0), 32'd5);
    end
    re0 = 1'b0;
    afl0 = 5'd8;
    for (int i = 0; i < 4; i++) begin
      wd0 = 8'($urandom);
      tick();
    end
    we0 = 1'b0;
    chk("pre_reset_level", 32'(lvl0), 32'd9);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_level", 32'(lvl0), 32'd0);
    chk("mid_rst_empty", 32'(rem0), 32'd1);
    chk("mid_rst_full", 32'(wf0), 32'd0);
    chk("mid_rst_afull", 32'(waf0), 32'd0);
    we0 = 1'b1; re0 = 1'b1; wd0 = 8'h77;
    tick();
    we0 = 1'b0; re0 = 1'b0; clr0 = 1'b1;
    chk("post_rst_read_rejected", 32'(un0), 32'd1);
    chk("post_rst_level", 32'(lvl0), 32'd1);
    afl0 = 5'd12;
    tick();
    clr0 = 1'b0;

    // 32-bit write, 8-bit FWFT read.
    we1 = 1'b1; wd1 = 32'h44332211;
    tick();
    we1 = 1'b0;
    chk("fwft_not_empty", 32'(rem1), 32'd0);
    chk("fwft_first", 32'(rd1), 32'h11);
    chk("fwft_level", 32'(lvl1), 32'd4);
    exp_b = '{8'h22, 8'h33, 8'h44};
    re1 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("fwft_pop_%0d", i), 32'(rd1), 32'(exp_b[i]));
    end
    tick();
    re1 = 1'b0;
    chk("fwft_drained", 32'(rem1), 32'd1);
    we1 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wd1 = $urandom;
      tick();
    end
    chk("wide_wr_not_full", 32'(wf1), 32'd0);
    wd1 = $urandom;
    tick();
    we1 = 1'b0;
    chk("wide_wr_full", 32'(wf1), 32'd1);
    re1 = 1'b1;
    for (int i = 0; i < 16; i++) tick();
    re1 = 1'b0;

    // 8-bit write, 32-bit read.
    exp_b = '{8'hAA, 8'hBB, 8'hCC};
    we2 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wd2 = exp_b[i];
      tick();
      chk($sformatf("narrow_wr_empty_%0d", i), 32'(rem2), 32'd1);
    end
    wd2 = 8'hDD;
    tick();
    we2 = 1'b0;
    chk("narrow_wr_ready", 32'(rem2), 32'd0);
    re2 = 1'b1;
    tick();
    re2 = 1'b0;
    chk("wide_rd_data", rd2, 32'hDDCCBBAA);
    chk("wide_rd_empty", 32'(rem2), 32'd1);

    // Randomized traffic on all three units: fill-biased, then drain-biased.
    for (int t = 0; t < 400; t++) begin
      logic fill;
      fill = (t % 100) < 50;
      we0 = fill ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      re0 = fill ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      we1 = fill ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 7) == 0);
      re1 = fill ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      we2 = fill ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      re2 = fill ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 3) == 0);
      wd0 = 8'($urandom); wd1 = $urandom; wd2 = 8'($urandom);
      clr0 = $urandom_range(0, 15) == 0;
      clr1 = $urandom_range(0, 15) == 0;
      clr2 = $urandom_range(0, 15) == 0;
      if ($urandom_range(0, 15) == 0) begin
        afl0 = 5'($urandom_range(0, 17)); ael0 = 5'($urandom_range(0, 17));
        afl1 = 5'($urandom_range(0, 17)); ael1 = 5'($urandom_range(0, 17));
        afl2 = 5'($urandom_range(0, 17)); ael2 = 5'($urandom_range(0, 17));
      end
      tick();
    end
    idle_inputs();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
